bcd_time_counter: RTL
=====================

# bcd_time_counter

Six-digit BCD timekeeper (HH:MM:SS, 24-hour) producing the six 4-bit digit values consumed by the display digit-select multiplexer. A prescaler divides the system clock down to a one-second tick. Cascaded BCD counters advance the time on each tick. A single-digit load port lets software or pushbutton logic set the time, with per-digit range checking.

## Interface
- TICK_DIV, 50_000_000, clock cycles per second tick; legal range 2..2^32-1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; release is synchronous to clk externally.
- run  in  1  count enable; 0 freezes the prescaler and the time.
- load  in  1  single-cycle strobe that writes one digit.
- load_sel  in  3  digit index for the load: 0 = seconds ones … 5 = hours tens; values 6 and 7 are illegal.
- load_val  in  4  BCD value for the load.
- digit0..digit5  out  4 each  seconds ones, seconds tens, minutes ones, minutes tens, hours ones, hours tens; they wire to mux inputs a..f in that order.
- sec_tick  out  1  one-cycle pulse marking each time increment.
- day_tick  out  1  one-cycle pulse when 23:59:59 wraps to 00:00:00.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Reset: all digits are 0, the prescaler is 0, pending is 0, and sec_tick, day_tick and load_err are 0.
- Prescaler: when run=1, it counts 0..TICK_DIV-1 and wraps. The internal tick is asserted in the cycle where count==TICK_DIV-1 and run=1. When run=0, the count holds.
- Increment order:
  - digit0 runs 0–9 and carries into digit1.
  - digit1 runs 0–5 and carries into digit2.
  - digit2 runs 0–9 and carries into digit3.
  - digit3 runs 0–5 and carries into the hours.
  - Hours: digit4 runs 0–9, except that after 23 both hour digits go to 0.
- Wrap: 23:59:59 goes to 00:00:00, and day_tick pulses together with sec_tick.
- Load legality:
  - Upper bounds by digit: digit0 ≤9, digit1 ≤5, digit2 ≤9, digit3 ≤5, digit4 ≤9, digit5 ≤2.
  - Hours cross-check: if load_sel=4, the value must be ≤3 when digit5==2. If load_sel=5 and the value is 2, digit4 must be ≤3.
  - load_sel 6 or 7, or any load_val > 9, is illegal.
  - An illegal load leaves all digits unchanged and pulses load_err.
- Legal load: only the selected digit is replaced. The prescaler is not affected.
- Load and tick in the same cycle:
  - The load wins that cycle.
  - The tick sets a pending flag, and the increment is applied on the next cycle instead. sec_tick and day_tick fire on that later cycle.
  - If another load arrives on the next cycle, pending stays set until a cycle without a load.
  - No tick is ever lost.
- Pending and a new tick together: this cannot occur while TICK_DIV ≥2 unless loads run back-to-back. If it does, only one increment is applied and one tick is dropped. This case is documented as unsupported stimulus.
- No interlock: loads are legal while run=1.

## Timing
- Digits are registered outputs. They change one cycle after the internal tick, or one cycle after the load strobe.
- sec_tick and day_tick are registered and asserted in the same cycle the new digit values first appear.
- load_err is asserted one cycle after the rejected load strobe.
- Throughput: one load per cycle.
- Time from run rising to the first increment: TICK_DIV cycles, counted from the current prescaler value.
- Reset asserted mid-operation clears everything immediately, independent of clk, including the pending flag.

## Structure
- Shared package contents:
  - Digit maximum constants (9, 5, 9, 5, 9, 2) and the hours limit 23.
  - The digit index enumeration, 0–5.
- Sub-module bcd_digit holds one BCD digit register with:
  - a MAX parameter,
  - an inc input, a synchronous clear input, a load input and a value input,
  - a carry-out asserted when inc=1 and value==MAX.
- The top level provides:
  - the prescaler,
  - the pending flag,
  - the load legality check,
  - the hours 23 wrap override, which applies synchronous clear to digit4 and digit5,
  - six bcd_digit instances.

## Test plan
All scenarios use TICK_DIV=4.
- Reset, then hold run=1 for 40 cycles. Expected: 10 sec_tick pulses, each 4 cycles apart, and digits 00:00:10 (digit1=1, digit0=0).
- Load the time 23:59:59 one digit at a time, then let it run until the next tick. Expected: 00:00:00, with sec_tick and day_tick in the same cycle.
- With digit5=2, load digit4=5. Expected: load_err pulses and digit4 is unchanged. Then load digit4=3. Expected: accepted, with no error.
- Assert load on the exact cycle the internal tick fires, writing digit2=7 from 00:00:09. Expected: the next cycle shows 00:07:09; the cycle after shows 00:07:10 with sec_tick.
- Take run low mid-count for 10 cycles, then high again. Expected: no ticks while low, and the next tick arrives after the prescaler's remaining count completes.
- Assert rst_n low asynchronously while pending=1 at 12:34:56. Expected: all outputs 0 immediately, and no increment after release.

Source files
------------

// File: rtl/bcd_time_counter_pkg.sv
// Shared constants and types for the HH:MM:SS BCD timekeeper.
// Digit order is seconds ones (0) up to hours tens (5).
package bcd_time_counter_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        DigSecOnes = 3'd0,
        DigSecTens = 3'd1,
        DigMinOnes = 3'd2,
        DigMinTens = 3'd3,
        DigHrOnes  = 3'd4,
        DigHrTens  = 3'd5
    } digit_idx_e;

    localparam int unsigned NumDigits = 6;

    localparam bcd_t MaxSecOnes = 4'd9;
    localparam bcd_t MaxSecTens = 4'd5;
    localparam bcd_t MaxMinOnes = 4'd9;
    localparam bcd_t MaxMinTens = 4'd5;
    localparam bcd_t MaxHrOnes  = 4'd9;
    localparam bcd_t MaxHrTens  = 4'd2;

    localparam int unsigned HoursLimit = 23;
    localparam bcd_t HrTensAtLimit = bcd_t'(HoursLimit / 10);
    localparam bcd_t HrOnesAtLimit = bcd_t'(HoursLimit % 10);

    function automatic bcd_t digit_max(logic [2:0] idx);
        case (idx)
            3'(DigSecOnes): return MaxSecOnes;
            3'(DigSecTens): return MaxSecTens;
            3'(DigMinOnes): return MaxMinOnes;
            3'(DigMinTens): return MaxMinTens;
            3'(DigHrOnes):  return MaxHrOnes;
            3'(DigHrTens):  return MaxHrTens;
            default:        return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/bcd_time_counter_if.sv
// Control and display bundle of the timekeeper: load port, run enable, six digits and pulses.
interface bcd_time_counter_if;
    import bcd_time_counter_pkg::*;

    logic       run;
    logic       load;
    logic [2:0] load_sel;
    bcd_t       load_val;
    bcd_t       digit0;
    bcd_t       digit1;
    bcd_t       digit2;
    bcd_t       digit3;
    bcd_t       digit4;
    bcd_t       digit5;
    logic       sec_tick;
    logic       day_tick;
    logic       load_err;

    modport master (
        output run, load, load_sel, load_val,
        input  digit0, digit1, digit2, digit3, digit4, digit5,
        input  sec_tick, day_tick, load_err
    );

    modport slave (
        input  run, load, load_sel, load_val,
        output digit0, digit1, digit2, digit3, digit4, digit5,
        output sec_tick, day_tick, load_err
    );

endinterface

// File: rtl/bcd_time_counter_bcd_digit.sv
// One BCD digit register counting 0..MAX with clear, load and increment.
// Priority is clear, then load, then increment.
module bcd_digit
    import bcd_time_counter_pkg::*;
#(
    parameter bcd_t MAX = 4'd9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    input  logic load_i,
    input  bcd_t val_i,
    output bcd_t q_o,
    output logic carry_o
);

    bcd_t digit_d, digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (load_i) begin
            digit_d = val_i;
        end else if (inc_i) begin
            digit_d = (digit_q == MAX) ? '0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign q_o     = digit_q;
    assign carry_o = inc_i && (digit_q == MAX);

endmodule

// File: rtl/bcd_time_counter.sv
// 24-hour HH:MM:SS BCD timekeeper: prescaler to a one-second tick, cascaded BCD digits,
// and a range-checked single-digit load port whose strobe defers a coincident tick by one cycle.
module bcd_time_counter
    import bcd_time_counter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input logic              clk,
    input logic              rst_n,
    bcd_time_counter_if.slave tc_if
);

    logic [31:0] cnt_d, cnt_q;
    logic        pending_d, pending_q;
    logic        sec_tick_d, sec_tick_q;
    logic        day_tick_d, day_tick_q;
    logic        load_err_d, load_err_q;

    logic        tick;
    logic        advance;
    logic        wrap;
    logic        load_legal;
    logic        load_ok;

    bcd_t                 digit_q [NumDigits];
    logic [NumDigits-1:0] carry;
    logic [NumDigits-1:0] inc_vec;
    logic [NumDigits-1:0] clr_vec;
    logic [NumDigits-1:0] ld_vec;

    assign tick = tc_if.run && (cnt_q == 32'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (tc_if.run) begin
            cnt_d = tick ? '0 : cnt_q + 32'd1;
        end
    end

    always_comb begin
        load_legal = 1'b1;
        if ((tc_if.load_sel > 3'd5) || (tc_if.load_val > 4'd9)) begin
            load_legal = 1'b0;
        end else if (tc_if.load_val > digit_max(tc_if.load_sel)) begin
            load_legal = 1'b0;
        end else if ((tc_if.load_sel == 3'(DigHrOnes)) && (digit_q[5] == HrTensAtLimit) &&
                     (tc_if.load_val > HrOnesAtLimit)) begin
            load_legal = 1'b0;
        end else if ((tc_if.load_sel == 3'(DigHrTens)) && (tc_if.load_val == HrTensAtLimit) &&
                     (digit_q[4] > HrOnesAtLimit)) begin
            load_legal = 1'b0;
        end
    end

    assign load_ok = tc_if.load && load_legal;

    // Any load strobe owns the cycle; a tick arriving then is parked in pending.
    assign advance   = (tick || pending_q) && !tc_if.load;
    assign pending_d = (tick || pending_q) && tc_if.load;

    assign wrap = carry[3] && (digit_q[5] == HrTensAtLimit) && (digit_q[4] == HrOnesAtLimit);

    always_comb begin
        inc_vec = {carry[4:0], advance};
        clr_vec = {wrap, wrap, 4'b0000};
        ld_vec  = '0;
        for (int i = 0; i < NumDigits; i++) begin
            ld_vec[i] = load_ok && (tc_if.load_sel == 3'(i));
        end
    end

    for (genvar i = 0; i < NumDigits; i++) begin : g_digit
        bcd_digit #(
            .MAX(digit_max(3'(i)))
        ) u_digit (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc_i  (inc_vec[i]),
            .clr_i  (clr_vec[i]),
            .load_i (ld_vec[i]),
            .val_i  (tc_if.load_val),
            .q_o    (digit_q[i]),
            .carry_o(carry[i])
        );
    end

    logic unused_carry;
    assign unused_carry = carry[5];

    always_comb begin
        sec_tick_d = advance;
        day_tick_d = wrap;
        load_err_d = tc_if.load && !load_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            day_tick_q <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            sec_tick_q <= sec_tick_d;
            day_tick_q <= day_tick_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc_if.digit0   = digit_q[0];
    assign tc_if.digit1   = digit_q[1];
    assign tc_if.digit2   = digit_q[2];
    assign tc_if.digit3   = digit_q[3];
    assign tc_if.digit4   = digit_q[4];
    assign tc_if.digit5   = digit_q[5];
    assign tc_if.sec_tick = sec_tick_q;
    assign tc_if.day_tick = day_tick_q;
    assign tc_if.load_err = load_err_q;

endmodule
